// File: rtl/sched_pkg.sv
// Shared definitions for the preemptive round-robin scheduler.
// Holds the FSM state encoding, the default geometry of the process table,
// and the PC constants used by the surrounding program-counter logic.
package sched_pkg;

  localparam int NUM_PROCS_DEF = 4;
  localparam int PID_W_DEF     = 2;
  localparam int ADDR_W_DEF    = 12;
  localparam int QUANTUM_DEF   = 256;

  // OS handler entry point loaded on jump_context_exchange.
  localparam logic [11:0] OS_ENTRY = 12'd1083;
  // Program counter value after CPU reset.
  localparam logic [11:0] RESET_PC = 12'd256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_OS      = 3'd3,
    ST_RESTORE = 3'd4
  } sched_state_e;

  // True while a context switch is in flight.
  function automatic logic is_busy(input sched_state_e st);
    return (st == ST_SAVE) || (st == ST_OS) || (st == ST_RESTORE);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Ports:
//   active   - runnable flag per process slot
//   cur_pid  - process currently owning the CPU
//   next_pid - first runnable slot after cur_pid (ascending, wrapping)
//   found    - 1 when a runnable slot other than cur_pid exists
module rr_picker #(
  parameter int NUM_PROCS = 4,
  parameter int PID_W     = 2
) (
  input  logic [NUM_PROCS-1:0] active,
  input  logic [PID_W-1:0]     cur_pid,
  output logic [PID_W-1:0]     next_pid,
  output logic                 found
);

  logic [PID_W-1:0] cand_s;

  // Scan offsets from farthest to nearest so the nearest runnable slot wins;
  // the PID_W-bit sum wraps naturally because NUM_PROCS is a power of two.
  always_comb begin
    next_pid = cur_pid;
    found    = 1'b0;
    cand_s   = cur_pid;
    for (int off = NUM_PROCS - 1; off >= 1; off--) begin
      cand_s = cur_pid + PID_W'(off);
      if (active[cand_s]) begin
        next_pid = cand_s;
        found    = 1'b1;
      end else begin
        next_pid = next_pid;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Preemptive round-robin process scheduler driving the program counter.
// Times each quantum, requests the OS handler, saves the interrupted PC and
// resumes the next runnable process once the handler reports completion.
// Ports:
//   clock, resetCPU        - clock and synchronous active-high reset
//   sched_en               - arms preemption
//   HLT                    - CPU halted; freezes the quantum while running
//   yield                  - software-requested switch (1-cycle pulse)
//   pc_next                - PC value being loaded this cycle (saved in SAVE)
//   os_done                - OS handler finished (1-cycle pulse)
//   cfg_we/pid/pc/active   - process slot configuration write
//   jump_context_exchange  - 1-cycle pulse: PC loads the OS entry
//   resume_jump            - 1-cycle pulse: PC loads resume_address
//   resume_address         - saved PC of the incoming process
//   current_pid            - process owning the CPU
//   sched_busy             - high during SAVE, OS and RESTORE
module quantum_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_PROCS = NUM_PROCS_DEF,
  parameter int PID_W     = PID_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int QUANTUM   = QUANTUM_DEF
) (
  input  logic              clock,
  input  logic              resetCPU,
  input  logic              sched_en,
  input  logic              HLT,
  input  logic              yield,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              os_done,
  input  logic              cfg_we,
  input  logic [PID_W-1:0]  cfg_pid,
  input  logic [ADDR_W-1:0] cfg_pc,
  input  logic              cfg_active,
  output logic              jump_context_exchange,
  output logic              resume_jump,
  output logic [ADDR_W-1:0] resume_address,
  output logic [PID_W-1:0]  current_pid,
  output logic              sched_busy
);

  localparam int              CNT_W      = $clog2(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(QUANTUM - 1);

  sched_state_e         state_r;
  sched_state_e         state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [PID_W-1:0]     cur_pid_r;
  logic [PID_W-1:0]     next_pid_r;
  logic [PID_W-1:0]     pick_pid_s;
  logic                 pick_found_s;
  logic [NUM_PROCS-1:0] active_r;
  logic [ADDR_W-1:0]    pc_table_r [NUM_PROCS];
  logic                 cnt_load_s;
  logic                 cnt_dec_s;
  logic                 take_pick_s;
  logic [ADDR_W-1:0]    restore_pc_s;
  logic                 jce_r;
  logic                 rj_r;
  logic                 busy_r;
  logic [ADDR_W-1:0]    raddr_r;

  rr_picker #(
    .NUM_PROCS (NUM_PROCS),
    .PID_W     (PID_W)
  ) u_picker (
    .active   (active_r),
    .cur_pid  (cur_pid_r),
    .next_pid (pick_pid_s),
    .found    (pick_found_s)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (resetCPU) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and counter control. HLT only freezes RUN; SAVE and RESTORE
  // are fixed single cycles and OS waits purely on os_done.
  always_comb begin
    state_nx_s  = state_r;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    take_pick_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sched_en) begin
          state_nx_s = ST_RUN;
          cnt_load_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!sched_en) begin
          state_nx_s = ST_IDLE;
        end else if (HLT) begin
          state_nx_s = ST_RUN;
        end else if ((cnt_r == {CNT_W{1'b0}}) || yield) begin
          // Timeout and yield together still give exactly one switch.
          if (pick_found_s) begin
            state_nx_s  = ST_SAVE;
            take_pick_s = 1'b1;
          end else begin
            cnt_load_s = 1'b1;
          end
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_SAVE: begin
        state_nx_s = ST_OS;
      end
      ST_OS: begin
        if (os_done) begin
          state_nx_s = ST_RESTORE;
        end else begin
          state_nx_s = ST_OS;
        end
      end
      ST_RESTORE: begin
        state_nx_s = ST_RUN;
        cnt_load_s = 1'b1;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // A cfg write landing on the restore slot in the os_done cycle must win.
  always_comb begin
    if (cfg_we && (cfg_pid == next_pid_r)) begin
      restore_pc_s = cfg_pc;
    end else begin
      restore_pc_s = pc_table_r[next_pid_r];
    end
  end

  // Quantum counter and process ownership.
  always_ff @(posedge clock) begin
    if (resetCPU) begin
      cnt_r      <= CNT_RELOAD;
      cur_pid_r  <= {PID_W{1'b0}};
      next_pid_r <= {PID_W{1'b0}};
    end else begin
      if (cnt_load_s) begin
        cnt_r <= CNT_RELOAD;
      end else if (cnt_dec_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (take_pick_s) begin
        next_pid_r <= pick_pid_s;
      end else begin
        next_pid_r <= next_pid_r;
      end
      if (state_r == ST_RESTORE) begin
        cur_pid_r <= next_pid_r;
      end else begin
        cur_pid_r <= cur_pid_r;
      end
    end
  end

  // Process table: SAVE beats a cfg write aimed at the same slot.
  always_ff @(posedge clock) begin
    if (resetCPU) begin
      active_r <= {NUM_PROCS{1'b0}};
      for (int i = 0; i < NUM_PROCS; i++) begin
        pc_table_r[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      if (cfg_we) begin
        active_r[cfg_pid] <= cfg_active;
      end else begin
        active_r <= active_r;
      end
      for (int i = 0; i < NUM_PROCS; i++) begin
        if ((state_r == ST_SAVE) && (cur_pid_r == PID_W'(i))) begin
          pc_table_r[i] <= pc_next;
        end else if (cfg_we && (cfg_pid == PID_W'(i))) begin
          pc_table_r[i] <= cfg_pc;
        end else begin
          pc_table_r[i] <= pc_table_r[i];
        end
      end
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clock) begin
    if (resetCPU) begin
      jce_r   <= 1'b0;
      rj_r    <= 1'b0;
      busy_r  <= 1'b0;
      raddr_r <= {ADDR_W{1'b0}};
    end else begin
      jce_r  <= (state_nx_s == ST_SAVE);
      rj_r   <= (state_nx_s == ST_RESTORE);
      busy_r <= is_busy(state_nx_s);
      if (state_nx_s == ST_RESTORE) begin
        raddr_r <= restore_pc_s;
      end else begin
        raddr_r <= raddr_r;
      end
    end
  end

  assign jump_context_exchange = jce_r;
  assign resume_jump           = rj_r;
  assign resume_address        = raddr_r;
  assign current_pid           = cur_pid_r;
  assign sched_busy            = busy_r;

endmodule
